// File: rtl/mips_pkg.sv
// Shared MIPS definitions: legal opcodes, the NOOP instruction word and the
// instruction-memory loader state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000001;
  localparam logic [5:0] OP_MVI   = 6'b101100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BNZ   = 6'b000111;
  localparam logic [5:0] OP_NOOP  = 6'b111111;

  localparam logic [31:0] NOOP_WORD = 32'hFC00003F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } loader_state_e;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_MVI, OP_SW, OP_LW, OP_BNZ, OP_NOOP: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/imem_opcheck.sv
// Opcode legality check with NOOP substitution for illegal words.
// Only compiled when IMEM_OPCHECK_EN is defined.
`ifdef IMEM_OPCHECK_EN
module imem_opcheck #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] word_in,
  output logic [DW-1:0] word_out,
  output logic          illegal
);
  import mips_pkg::*;

  always_comb begin
    illegal  = !opcode_legal(word_in[DW-1:DW-6]);
    word_out = illegal ? DW'(NOOP_WORD) : word_in;
  end

endmodule
`endif

// File: rtl/imem_loader.sv
// Copies the instruction FIFO into instruction memory from address 0 and holds
// the pipeline in reset until loading ends (idle timeout or memory full).
// Optional opcode checking is enabled with IMEM_OPCHECK_EN.
module imem_loader #(
  parameter int unsigned AW           = 5,
  parameter int unsigned DW           = 32,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic          clkLOW,
  input  logic          rst,
  input  logic          load_req,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          pipe_hold,
  output logic          load_done,
  output logic [AW:0]   word_count,
  output logic          illegal_op
);
  import mips_pkg::*;

  localparam int unsigned TW           = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_W      = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LAST_W       = {1'b0, {AW{1'b1}}};
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);

  loader_state_e state, state_next;
  logic [TW-1:0] timer;
  logic          pop;
  logic          start;
  logic [DW-1:0] write_word;
  logic          write_illegal;

`ifdef IMEM_OPCHECK_EN
  imem_opcheck #(.DW(DW)) u_opcheck (
    .word_in  (fifo_dout),
    .word_out (write_word),
    .illegal  (write_illegal)
  );
`else
  assign write_word    = fifo_dout;
  assign write_illegal = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_next = LOAD;
          start      = 1'b1;
        end
      end
      LOAD: begin
        pop = !fifo_empty && (word_count < DEPTH_W);
        // The timer only runs once something is loaded, so an empty start waits forever.
        if (pop && (word_count == LAST_W)) begin
          state_next = FLUSH;
        end else if (!pop && (word_count != '0) && (timer == TIMEOUT_LAST)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: state_next = RUN;
      RUN: begin
        if (load_req) begin
          state_next = LOAD;
          start      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_rd_en = pop;
  assign pipe_hold  = (state != RUN);
  assign load_done  = (state == RUN);

  always_ff @(posedge clkLOW) begin
    if (rst) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      timer      <= '0;
      illegal_op <= 1'b0;
    end else begin
      state   <= state_next;
      imem_we <= pop;
      if (start) begin
        word_count <= '0;
        timer      <= '0;
        illegal_op <= 1'b0;
      end else if (pop) begin
        imem_addr  <= word_count[AW-1:0];
        imem_wdata <= write_word;
        word_count <= word_count + (AW+1)'(1);
        timer      <= '0;
        if (write_illegal) begin
          illegal_op <= 1'b1;
        end
      end else if ((state == LOAD) && (word_count != '0)) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a show-ahead FIFO model.
module tb_imem_loader;

  logic        clkLOW = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        pipe_hold;
  logic        load_done;
  logic [5:0]  word_count;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic        pend_pop = 1'b0;
  int          pops = 0;
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.AW(5), .DW(32), .IDLE_TIMEOUT(8)) dut (
    .clkLOW     (clkLOW),
    .rst        (rst),
    .load_req   (load_req),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pipe_hold  (pipe_hold),
    .load_done  (load_done),
    .word_count (word_count),
    .illegal_op (illegal_op)
  );

  always #5 clkLOW = ~clkLOW;

  // Monitor: sample pop strobe and memory writes mid-cycle.
  always @(negedge clkLOW) begin
    pend_pop = fifo_rd_en;
    if (fifo_rd_en) pops++;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  // FIFO model: pop and present the new head just after the edge.
  always @(posedge clkLOW) begin
    #1;
    if (pend_pop && q.size() != 0) void'(q.pop_front());
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() == 0) ? 32'h0 : q[0];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkLOW);
    #2;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", imem_we); end
    checks++; if (imem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
    checks++; if (pipe_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", pipe_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", load_done); end
    checks++; if (word_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", word_count); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    rst = 1'b0;
    tick();
    checks++; if ({pipe_hold, fifo_rd_en} !== 2'b10) begin errors++; $display("FAIL idle_after_reset: got hold/rd %b want 10", {pipe_hold, fifo_rd_en}); end
  endtask

  task automatic test_timeout_load();
    logic [31:0] w[5];
    int done_at, pb, wb;
    w = '{32'hB0010001, 32'hAC020002, 32'hB0030003, 32'hAC040004, 32'hB0050005};
    for (int k = 0; k < 5; k++) q.push_back(w[k]);
    pb = pops; wb = wr_addr.size();
    pulse_load();
    checks++; if ({pipe_hold, load_done, fifo_rd_en} !== 3'b101) begin errors++; $display("FAIL tmo_enter_load: got hold/done/rd %b want 101", {pipe_hold, load_done, fifo_rd_en}); end
    done_at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 1) begin
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 5'd0, w[0]}) begin errors++; $display("FAIL tmo_first_write: got we %b addr %0d data %h want 1 0 %h", imem_we, imem_addr, imem_wdata, w[0]); end
      end
      if (i == 13) begin
        checks++; if ({pipe_hold, load_done, imem_we} !== 3'b100) begin errors++; $display("FAIL tmo_flush: got hold/done/we %b want 100", {pipe_hold, load_done, imem_we}); end
      end
      if (load_done === 1'b1) begin done_at = i; break; end
    end
    checks++; if (done_at !== 14) begin errors++; $display("FAIL tmo_run_cycle: got %0d want 14", done_at); end
    checks++; if (wr_addr.size() - wb !== 5) begin errors++; $display("FAIL tmo_write_count: got %0d want 5", wr_addr.size() - wb); end
    for (int k = 0; k < 5; k++) begin
      checks++; if ({wr_addr[wb+k], wr_data[wb+k]} !== {5'(k), w[k]}) begin errors++; $display("FAIL tmo_write%0d: got addr %0d data %h want %0d %h", k, wr_addr[wb+k], wr_data[wb+k], k, w[k]); end
    end
    checks++; if (word_count !== 6'd5) begin errors++; $display("FAIL tmo_word_count: got %0d want 5", word_count); end
    checks++; if (pops - pb !== 5) begin errors++; $display("FAIL tmo_pops: got %0d want 5", pops - pb); end
    checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL tmo_hold_released: got %b want 0", pipe_hold); end
  endtask

  task automatic test_full();
    int done_at, pb, wb, bad;
    for (int k = 0; k < 42; k++) q.push_back(32'h04000000 + k);
    pb = pops; wb = wr_addr.size();
    pulse_load();
    checks++; if ({pipe_hold, load_done, word_count} !== {1'b1, 1'b0, 6'd0}) begin errors++; $display("FAIL full_reload_entry: got hold %b done %b count %0d want 1 0 0", pipe_hold, load_done, word_count); end
    done_at = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 32) begin
        checks++; if ({imem_we, imem_addr, fifo_rd_en, pipe_hold} !== {1'b1, 5'd31, 1'b0, 1'b1}) begin errors++; $display("FAIL full_last_write: got we %b addr %0d rd %b hold %b want 1 31 0 1", imem_we, imem_addr, fifo_rd_en, pipe_hold); end
      end
      if (load_done === 1'b1) begin done_at = i; break; end
    end
    checks++; if (done_at !== 33) begin errors++; $display("FAIL full_run_cycle: got %0d want 33", done_at); end
    checks++; if (pops - pb !== 32) begin errors++; $display("FAIL full_pops: got %0d want 32", pops - pb); end
    checks++; if (wr_addr.size() - wb !== 32) begin errors++; $display("FAIL full_write_count: got %0d want 32", wr_addr.size() - wb); end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if ({wr_addr[wb+k], wr_data[wb+k]} !== {5'(k), 32'h04000000 + 32'(k)}) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_write_contents: got %0d bad entries want 0", bad); end
    checks++; if (q.size() !== 10) begin errors++; $display("FAIL full_fifo_left: got %0d want 10", q.size()); end
    checks++; if (word_count !== 6'd32) begin errors++; $display("FAIL full_word_count: got %0d want 32", word_count); end
    q.delete();
  endtask

  task automatic test_gap();
    logic [31:0] w[5];
    int done_at, wb;
    w = '{32'hAC100000, 32'hAC100001, 32'hB0100002, 32'hB0100003, 32'hB0100004};
    q.push_back(w[0]);
    q.push_back(w[1]);
    tick();
    wb = wr_addr.size();
    pulse_load();
    done_at = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 8) begin
        for (int k = 2; k < 5; k++) q.push_back(w[k]);
      end
      if (load_done === 1'b1) begin done_at = i; break; end
    end
    checks++; if (done_at !== 21) begin errors++; $display("FAIL gap_run_cycle: got %0d want 21", done_at); end
    checks++; if (wr_addr.size() - wb !== 5) begin errors++; $display("FAIL gap_write_count: got %0d want 5", wr_addr.size() - wb); end
    for (int k = 0; k < 5; k++) begin
      checks++; if ({wr_addr[wb+k], wr_data[wb+k]} !== {5'(k), w[k]}) begin errors++; $display("FAIL gap_write%0d: got addr %0d data %h want %0d %h", k, wr_addr[wb+k], wr_data[wb+k], k, w[k]); end
    end
    checks++; if (word_count !== 6'd5) begin errors++; $display("FAIL gap_word_count: got %0d want 5", word_count); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] exp0;
    int done_at, pb, wb;
    for (int k = 0; k < 6; k++) q.push_back(32'hB0200000 + k);
    tick();
    wb = wr_addr.size();
    pulse_load();
    tick();
    tick();
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rst_pop_cycle: got rd %b want 1", fifo_rd_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({imem_we, word_count, pipe_hold, load_done, fifo_rd_en} !== {1'b0, 6'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_mid_load: got we %b count %0d hold %b done %b rd %b want 0 0 1 0 0", imem_we, word_count, pipe_hold, load_done, fifo_rd_en); end
    rst = 1'b1;
    load_req = 1'b1;
    tick();
    rst = 1'b0;
    load_req = 1'b0;
    tick();
    checks++; if ({fifo_rd_en, pipe_hold} !== 2'b01) begin errors++; $display("FAIL rst_beats_load_req: got rd/hold %b want 01", {fifo_rd_en, pipe_hold}); end
    checks++; if (wr_addr.size() - wb !== 2) begin errors++; $display("FAIL rst_dropped_write: got %0d writes want 2", wr_addr.size() - wb); end
    exp0 = q[0];
    checks++; if (exp0 !== 32'hB0200003) begin errors++; $display("FAIL rst_fifo_head: got %h want b0200003", exp0); end
    pb = pops; wb = wr_addr.size();
    pulse_load();
    tick();
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 5'd0, 32'hB0200003}) begin errors++; $display("FAIL rst_reload_first: got we %b addr %0d data %h want 1 0 b0200003", imem_we, imem_addr, imem_wdata); end
    done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load_done === 1'b1) begin done_at = i; break; end
    end
    checks++; if (done_at === 0) begin errors++; $display("FAIL rst_reload_done: got no RUN within 40 cycles want RUN"); end
    checks++; if ({word_count, 6'(pops - pb), 6'(wr_addr.size() - wb)} !== {6'd3, 6'd3, 6'd3}) begin errors++; $display("FAIL rst_reload_counts: got count %0d pops %0d writes %0d want 3 3 3", word_count, pops - pb, wr_addr.size() - wb); end
    checks++; if (wr_addr[wb+2] !== 5'd2) begin errors++; $display("FAIL rst_reload_last_addr: got %0d want 2", wr_addr[wb+2]); end
  endtask

  task automatic test_opcode();
    logic [31:0] exp_word;
    logic        exp_ill;
    int done_at, wb;
`ifdef IMEM_OPCHECK_EN
    exp_word = 32'hFC00003F;
    exp_ill  = 1'b1;
`else
    exp_word = 32'h50505050;
    exp_ill  = 1'b0;
`endif
    q.push_back(32'h50505050);
    q.push_back(32'hB0000007);
    tick();
    wb = wr_addr.size();
    pulse_load();
    done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        checks++; if ({imem_wdata, illegal_op} !== {exp_word, exp_ill}) begin errors++; $display("FAIL op_illegal_write: got data %h flag %b want %h %b", imem_wdata, illegal_op, exp_word, exp_ill); end
      end
      if (load_done === 1'b1) begin done_at = i; break; end
    end
    checks++; if (done_at !== 11) begin errors++; $display("FAIL op_run_cycle: got %0d want 11", done_at); end
    checks++; if (wr_data[wb+1] !== 32'hB0000007) begin errors++; $display("FAIL op_legal_write: got %h want b0000007", wr_data[wb+1]); end
    checks++; if (illegal_op !== exp_ill) begin errors++; $display("FAIL op_flag_sticky: got %b want %b", illegal_op, exp_ill); end
    q.push_back(32'h8C000008);
    tick();
    pulse_load();
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL op_flag_cleared: got %b want 0", illegal_op); end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load_done === 1'b1) break;
    end
    checks++; if ({word_count, illegal_op, imem_wdata} !== {6'd1, 1'b0, 32'h8C000008}) begin errors++; $display("FAIL op_lw_reload: got count %0d flag %b data %h want 1 0 8c000008", word_count, illegal_op, imem_wdata); end
  endtask

  initial begin
    test_reset();
    test_timeout_load();
    test_full();
    test_gap();
    test_reset_mid_load();
    test_opcode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
